// File: rtl/clk_sw_pkg.sv
// Shared types and defaults for the clock-switch sequencer.
// The CLK_SW_DWELL_EN macro (read by clk_sw_ctrl) enables the post-switch HOLD/dwell phase.
package clk_sw_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OFF = 2'd1,
    WAIT_ON  = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic SRC_CLK0 = 1'b0;
  localparam logic SRC_CLK1 = 1'b1;

  localparam logic DEF_RESET_SRC      = SRC_CLK0;
  localparam int   DEF_SYNC_STAGES    = 2;
  localparam int   DEF_TIMEOUT_CYCLES = 256;
  localparam int   DEF_DWELL_CYCLES   = 16;
  localparam int   DEF_CNT_W          = 9;

endpackage

// File: rtl/clk_sw_ctrl_if.sv
// Request handshake between a switch requester and the clock-switch sequencer.
interface clk_sw_ctrl_if;
  logic req_valid;
  logic req_src;
  logic req_ready;
  logic done;

  modport master (output req_valid, output req_src, input req_ready, input done);
  modport slave  (input req_valid, input req_src, output req_ready, output done);
endinterface

// File: rtl/clk_sw_ctrl_sync_bit.sv
// Multi-flop single-bit synchroniser with asynchronous active-low reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_sw_ctrl.sv
// Switch sequencer for a two-input glitch-free clock mux: select, confirm handover, dwell, timeout.
// Define CLK_SW_DWELL_EN to hold DWELL_CYCLES after each completed switch before accepting another.
module clk_sw_ctrl
  import clk_sw_pkg::*;
#(
  parameter logic RESET_SRC      = DEF_RESET_SRC,
  parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int   TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int   DWELL_CYCLES   = DEF_DWELL_CYCLES,
  parameter int   CNT_W          = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  clk_sw_ctrl_if.slave req,
  input  logic [1:0]   en_stat,
  output logic         sel,
  output logic         cur_src,
  output logic         busy,
  output logic         err,
  input  logic         err_clr
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0] s_en;

  for (genvar i = 0; i < 2; i++) begin : g_sync
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (en_stat[i]),
      .q    (s_en[i])
    );
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             cur_q, cur_d;
  logic             tgt_q, tgt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= RESET_SRC;
      cur_q   <= RESET_SRC;
      tgt_q   <= RESET_SRC;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    err_d   = err_clr ? 1'b0 : err_q;

    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          if (req.req_src == cur_q) begin
            done_d = 1'b1;
          end else begin
            sel_d   = req.req_src;
            tgt_d   = req.req_src;
            cnt_d   = '0;
            state_d = WAIT_OFF;
          end
        end
      end

      WAIT_OFF: begin
        // Timeout wins over a late off-confirmation: sel already points at the target.
        if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cur_d   = tgt_q;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!s_en[cur_q]) state_d = WAIT_ON;
        end
      end

      WAIT_ON: begin
        if (s_en[tgt_q]) begin
          cur_d = tgt_q;
          cnt_d = '0;
`ifdef CLK_SW_DWELL_EN
          state_d = HOLD;
`else
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cur_d   = tgt_q;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Unreachable when the dwell phase is disabled; kept so the state decode stays total.
      HOLD: begin
        if (cnt_q == DW_LAST) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sel           = sel_q;
  assign cur_src       = cur_q;
  assign err           = err_q;
  assign busy          = (state_q != IDLE);
  assign req.req_ready = (state_q == IDLE);
  assign req.done      = done_q;

endmodule

// File: doc/clk_sw_ctrl.md
Name: clk_sw_ctrl

Overview:
Switch sequencer for the two-input glitch_free clock mux. It runs on an always-on reference clock and accepts source-switch requests over a valid/ready handshake. It drives the mux select and tracks the mux's per-source enable status, which it synchronises locally, to confirm handover. It also enforces a minimum dwell time between switches and flags a stuck switch through a timeout.

Parameters:
RESET_SRC, 0, source selected out of reset (0 = clk0, 1 = clk1)
SYNC_STAGES, 2, flip-flop depth of each status synchroniser (min 2)
TIMEOUT_CYCLES, 256, max clk cycles allowed from select change to new-source-enabled
DWELL_CYCLES, 16, min clk cycles held after a completed switch before the next request is accepted
CNT_W, 9, counter width; must hold max(TIMEOUT_CYCLES, DWELL_CYCLES)

Ports:
clk  in  1  always-on reference clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  switch request valid
req_src  in  1  requested source
req_ready  out  1  request accepted when req_valid & req_ready
en_stat  in  2  mux per-source enable status, bit i for clk_i (asynchronous to clk)
sel  out  1  mux select, registered
cur_src  out  1  source currently confirmed active
busy  out  1  switch sequence in progress
done  out  1  one-cycle pulse, request finished
err  out  1  sticky timeout flag
err_clr  in  1  clears err

Behaviour:
- Reset (async assert, sync release) gives: sel=RESET_SRC, cur_src=RESET_SRC, busy=0, done=0, err=0, req_ready=1, state=IDLE, counter=0.
- en_stat bits pass through SYNC_STAGES flops before use. The synced values are s_en[1:0].
- States are IDLE, WAIT_OFF, WAIT_ON and HOLD.
- req_ready=1 only in IDLE. busy=1 in any state other than IDLE.
- IDLE, handshake with req_src==cur_src: no-op. done pulses the next cycle and the state stays IDLE.
- IDLE, handshake with req_src!=cur_src: on the next edge, sel<=req_src, the target is latched, the counter is cleared, and the state goes to WAIT_OFF.
- WAIT_OFF: wait for s_en[cur_src]==0, then go to WAIT_ON.
- WAIT_ON: wait for s_en[target]==1. When seen, cur_src<=target, the counter is cleared, and the state goes to HOLD.
- HOLD: count DWELL_CYCLES cycles. On the last one, pulse done and go to IDLE.
- Timeout: the counter runs across WAIT_OFF and WAIT_ON combined. When it reaches TIMEOUT_CYCLES-1 without completion:
  - err<=1 and cur_src<=target, because sel already points to target.
  - done pulses and the state goes straight to IDLE, skipping HOLD.
- err_clr clears err on the next edge. If err_clr and a timeout occur in the same cycle, the set wins.
- req_src and req_valid are ignored while busy. The requester must hold req_valid.
- Reset asserted mid-sequence: all outputs return to reset values immediately. The mux is responsible for safe switching on the resulting sel change.
- Latency, ideal mux: handshake to done = 1 + (off sync) + (on sync) + DWELL_CYCLES cycles minimum.

Optional Feature:
CLK_SW_DWELL_EN
- Defined: HOLD state and DWELL_CYCLES enforcement behave as above.
- Undefined: HOLD is removed. WAIT_ON success goes directly to IDLE with the done pulse, and DWELL_CYCLES is unused.

Decomposition:
- Shared package/include clk_sw_pkg holds:
  - state encodings: IDLE=2'd0, WAIT_OFF=2'd1, WAIT_ON=2'd2, HOLD=2'd3
  - default parameter constants
  - the src encoding (SRC_CLK0=0, SRC_CLK1=1)
- One natural sub-module, sync_bit: an SYNC_STAGES-deep single-bit synchroniser with async active-low reset. It is instantiated twice, once per en_stat bit.

Test Plan:
- Reset release with RESET_SRC=0 and en_stat=2'b01 → sel=0, cur_src=0, req_ready=1, err=0, done=0.
- Request src=1 with en_stat dropping bit0 after 5 cycles and raising bit1 after 8 cycles → sel=1 one cycle after handshake; cur_src=1 once synced bit1 is seen; done pulses DWELL_CYCLES=16 cycles later; busy high throughout.
- Request src=1 while cur_src=1 → done pulse one cycle after handshake; sel unchanged; busy never asserts.
- Request src=0 with en_stat bit0 never rising, TIMEOUT_CYCLES=256 → err=1 and done pulse 256 cycles after entering WAIT_OFF; cur_src=0. A later err_clr clears err; err_clr coinciding with a second timeout leaves err=1.
- New req_valid asserted during HOLD → req_ready=0 until HOLD ends, then accepted. Repeat with CLK_SW_DWELL_EN undefined → accepted the cycle after done.
- rst_n asserted during WAIT_ON → sel and cur_src immediately return to RESET_SRC, busy=0, req_ready=1 after release.
